// File: rtl/eth_10g_block_lock_ctrl.sv
// 64b/66b block-lock controller for a GTX RX lane: hunts for sync-header alignment
// by pulsing RXSLIP, then monitors header errors per window while locked.
module eth_10g_block_lock_ctrl #(
  parameter int unsigned LOCK_COUNT       = 64,
  parameter int unsigned WINDOW_LEN       = 64,
  parameter int unsigned INVALID_LIMIT    = 16,
  parameter int unsigned SLIP_WAIT_CYCLES = 32,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_rxheader,
  input  logic                 i_rxheader_valid,
  input  logic                 i_clear_counts,
  output logic                 o_rxslip,
  output logic                 o_block_lock,
  output logic [CNT_WIDTH-1:0] o_slip_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int unsigned SH_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW_LEN + 1);
  localparam int unsigned INV_W = $clog2(INVALID_LIMIT + 1);
  localparam int unsigned WT_W  = $clog2(SLIP_WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [SH_W-1:0]  sh_cnt, sh_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [INV_W-1:0] inv_cnt, inv_nxt;
  logic [WT_W-1:0]  wait_cnt, wait_nxt;
  logic             slip_inc, err_inc;
  logic             hdr_good;

  assign hdr_good = i_rxheader[1] ^ i_rxheader[0];

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    win_nxt   = win_cnt;
    inv_nxt   = inv_cnt;
    wait_nxt  = wait_cnt;
    slip_inc  = 1'b0;
    err_inc   = 1'b0;
    if (!i_enable) begin
      state_nxt = HUNT;
      sh_nxt    = '0;
      win_nxt   = '0;
      inv_nxt   = '0;
      wait_nxt  = '0;
    end else begin
      case (state)
        HUNT: begin
          if (i_rxheader_valid) begin
            if (!hdr_good) begin
              state_nxt = SLIP;
              slip_inc  = 1'b1;
              sh_nxt    = '0;
            end else if (sh_cnt == SH_W'(LOCK_COUNT - 1)) begin
              state_nxt = LOCKED;
              sh_nxt    = '0;
              win_nxt   = '0;
              inv_nxt   = '0;
            end else begin
              sh_nxt = sh_cnt + 1'b1;
            end
          end
        end
        SLIP: begin
          state_nxt = SLIP_WAIT;
          wait_nxt  = WT_W'(SLIP_WAIT_CYCLES - 1);
        end
        SLIP_WAIT: begin
          if (wait_cnt == '0) begin
            state_nxt = HUNT;
            sh_nxt    = '0;
          end else begin
            wait_nxt = wait_cnt - 1'b1;
          end
        end
        LOCKED: begin
          if (i_rxheader_valid) begin
            err_inc = !hdr_good;
            // Loss of lock wins over a coincident window end.
            if (!hdr_good && inv_cnt == INV_W'(INVALID_LIMIT - 1)) begin
              state_nxt = SLIP;
              slip_inc  = 1'b1;
              win_nxt   = '0;
              inv_nxt   = '0;
            end else if (win_cnt == WIN_W'(WINDOW_LEN - 1)) begin
              win_nxt = '0;
              inv_nxt = '0;
            end else begin
              win_nxt = win_cnt + 1'b1;
              inv_nxt = inv_cnt + INV_W'(!hdr_good);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= HUNT;
      sh_cnt       <= '0;
      win_cnt      <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_rxslip     <= 1'b0;
      o_block_lock <= 1'b0;
      o_slip_count <= '0;
      o_err_count  <= '0;
    end else begin
      state        <= state_nxt;
      sh_cnt       <= sh_nxt;
      win_cnt      <= win_nxt;
      inv_cnt      <= inv_nxt;
      wait_cnt     <= wait_nxt;
      o_rxslip     <= (state_nxt == SLIP);
      o_block_lock <= (state_nxt == LOCKED);
      if (i_clear_counts)
        o_slip_count <= '0;
      else if (slip_inc && o_slip_count != '1)
        o_slip_count <= o_slip_count + 1'b1;
      if (i_clear_counts)
        o_err_count <= '0;
      else if (err_inc && o_err_count != '1)
        o_err_count <= o_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_10g_block_lock_ctrl.sv
// Directed self-checking bench for eth_10g_block_lock_ctrl.
module tb_eth_10g_block_lock_ctrl;

  // Narrow statistics so counter saturation is reachable in a short run.
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    rxheader = 2'b00;
  logic          rxheader_valid = 1'b0;
  logic          clear_counts = 1'b0;
  logic          rxslip;
  logic          block_lock;
  logic [CW-1:0] slip_count;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  eth_10g_block_lock_ctrl #(
    .LOCK_COUNT      (64),
    .WINDOW_LEN      (64),
    .INVALID_LIMIT   (16),
    .SLIP_WAIT_CYCLES(32),
    .CNT_WIDTH       (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_rxheader      (rxheader),
    .i_rxheader_valid(rxheader_valid),
    .i_clear_counts  (clear_counts),
    .o_rxslip        (rxslip),
    .o_block_lock    (block_lock),
    .o_slip_count    (slip_count),
    .o_err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] hdr, input logic vld);
    rxheader       = hdr;
    rxheader_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxslip"}, {31'd0, rxslip}, 32'd0);
    check({tag, "_lock"},   {31'd0, block_lock}, 32'd0);
    check({tag, "_slipcnt"}, 32'(slip_count), 32'd0);
    check({tag, "_errcnt"},  32'(err_count), 32'd0);
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < 64; i++) begin
      step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      check({tag, "_lock"}, {31'd0, block_lock}, (i == 63) ? 32'd1 : 32'd0);
      check({tag, "_noslip"}, {31'd0, rxslip}, 32'd0);
    end
  endtask

  initial begin
    // 1: reset, then acquire lock with 64 good headers
    rst = 1'b1;
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    rst = 1'b0;
    check_all_zero("t1_reset");
    enable = 1'b1;
    lock_up("t1");
    check("t1_slipcnt", 32'(slip_count), 32'd0);

    // 2: bad header in HUNT -> one slip, 33 ignored headers, relock after 64 good
    rst = 1'b1;
    step(2'b00, 1'b0);
    rst = 1'b0;
    check_all_zero("t2_reset");
    for (int i = 0; i < 10; i++) step(2'b01, 1'b1);
    check("t2_prelock", {31'd0, block_lock}, 32'd0);
    step(2'b11, 1'b1);
    check("t2_slip", {31'd0, rxslip}, 32'd1);
    check("t2_slipcnt", 32'(slip_count), 32'd1);
    for (int i = 0; i < 33; i++) begin
      step(2'b11, 1'b1);
      check("t2_wait_noslip", {31'd0, rxslip}, 32'd0);
    end
    lock_up("t2");
    check("t2_slipcnt_end", 32'(slip_count), 32'd1);

    // 3: 15 bad in one window keeps lock; 16 in the next loses it
    for (int i = 0; i < 64; i++) begin
      step((i % 4 == 0 && i < 60) ? 2'b11 : 2'b10, 1'b1);
      check("t3_w1_lock", {31'd0, block_lock}, 32'd1);
      check("t3_w1_noslip", {31'd0, rxslip}, 32'd0);
    end
    check("t3_err15", 32'(err_count), 32'd15);
    for (int i = 0; i <= 60; i++) begin
      step((i % 4 == 0) ? 2'b00 : 2'b01, 1'b1);
      check("t3_w2_lock", {31'd0, block_lock}, (i == 60) ? 32'd0 : 32'd1);
      check("t3_w2_slip", {31'd0, rxslip}, (i == 60) ? 32'd1 : 32'd0);
    end
    check("t3_err31", 32'(err_count), 32'd31);
    check("t3_slipcnt", 32'(slip_count), 32'd2);
    for (int i = 0; i < 33; i++) step(2'b11, 1'b1);
    lock_up("t3_relock");

    // 4: valid toggling; invalid bad headers ignored, window spans 128 cycles
    for (int c = 0; c < 128; c++) begin
      if (c % 2 == 0) step((c / 2 < 15) ? 2'b00 : 2'b10, 1'b1);
      else            step(2'b11, 1'b0);
      check("t4_wa_lock", {31'd0, block_lock}, 32'd1);
    end
    check("t4_err46", 32'(err_count), 32'd46);
    for (int c = 0; c <= 78; c++) begin
      if (c % 2 == 0) step((c / 2 >= 24 && c / 2 <= 39) ? 2'b11 : 2'b01, 1'b1);
      else            step(2'b00, 1'b0);
      check("t4_wb_lock", {31'd0, block_lock}, (c == 78) ? 32'd0 : 32'd1);
    end
    check("t4_slip", {31'd0, rxslip}, 32'd1);
    check("t4_err62", 32'(err_count), 32'd62);
    check("t4_slipcnt", 32'(slip_count), 32'd3);

    // 5: reset mid SLIP_WAIT, then disable while locked
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b1);
      check("t5_wait_noslip", {31'd0, rxslip}, 32'd0);
    end
    rst = 1'b1;
    step(2'b11, 1'b1);
    rst = 1'b0;
    check_all_zero("t5_reset");
    lock_up("t5_lock");
    step(2'b11, 1'b1);
    check("t5_err1", 32'(err_count), 32'd1);
    check("t5_still_lock", {31'd0, block_lock}, 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b1);
      check("t5_dis_lock", {31'd0, block_lock}, 32'd0);
      check("t5_dis_noslip", {31'd0, rxslip}, 32'd0);
    end
    check("t5_dis_slipcnt", 32'(slip_count), 32'd0);
    check("t5_dis_err", 32'(err_count), 32'd1);
    enable = 1'b1;
    lock_up("t5_relock");

    // 6: slip counter saturation and clear-over-increment priority
    rst = 1'b1;
    step(2'b00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 341; i++) step(2'b11, 1'b1);
    check("t6_slip11", 32'(slip_count), 32'd11);
    check("t6_slip11_pulse", {31'd0, rxslip}, 32'd1);
    for (int i = 0; i < 34 * 250; i++) step(2'b11, 1'b1);
    check("t6_sat", 32'(slip_count), 32'hFF);
    for (int i = 0; i < 100; i++) step(2'b11, 1'b1);
    check("t6_sat_hold", 32'(slip_count), 32'hFF);
    enable = 1'b0;
    step(2'b11, 1'b1);
    check("t6_dis_hold", 32'(slip_count), 32'hFF);
    enable = 1'b1;
    clear_counts = 1'b1;
    step(2'b11, 1'b1);
    clear_counts = 1'b0;
    check("t6_clr_slip", {31'd0, rxslip}, 32'd1);
    check("t6_clr_cnt", 32'(slip_count), 32'd0);
    step(2'b11, 1'b1);
    check("t6_clr_after", 32'(slip_count), 32'd0);
    check("t6_clr_noslip", {31'd0, rxslip}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
